// File: rtl/mul4_eval_pkg.sv
// Shared types and constants for the 2x2-bit multiplier fitness evaluator.
// Holds the FSM encoding, exhaustive stimulus words, LFSR taps and the golden product.
package mul4_eval_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SCORE,
      DONE
   } state_t;

   // Lane l of these four words enumerates operand pair (a,b) = (l>>2, l&3).
   localparam logic [15:0] EXH_A1 = 16'hFF00;
   localparam logic [15:0] EXH_A0 = 16'hF0F0;
   localparam logic [15:0] EXH_B1 = 16'hCCCC;
   localparam logic [15:0] EXH_B0 = 16'hAAAA;

   // Feedback taps at bits 63, 62, 60 and 59.
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   typedef struct packed {
      logic [15:0] y3;
      logic [15:0] y2;
      logic [15:0] y1;
      logic [15:0] y0;
   } prod_t;

   function automatic prod_t golden_product(input logic [15:0] a1, input logic [15:0] a0,
                                            input logic [15:0] b1, input logic [15:0] b0);
      prod_t p;
      p.y0 = a0 & b0;
      p.y1 = (a1 & b0) ^ (a0 & b1);
      p.y2 = a1 & b1 & ~(a0 & b0);
      p.y3 = a1 & a0 & b1 & b0;
      return p;
   endfunction

endpackage

// File: rtl/mul4_eval_popcount64.sv
// Combinational population count of 64 match bits, built as four 16-bit
// partial counts summed into a 7-bit result.
module mul4_eval_popcount64 (
   input  logic [63:0] bits,
   output logic [6:0]  count
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_part
      logic [4:0] sum;
      always_comb begin
         sum = '0;
         for (int i = 0; i < 16; i++) begin
            sum = sum + 5'(bits[gi*16 + i]);
         end
      end
   end

   assign count = 7'(g_part[0].sum) + 7'(g_part[1].sum)
                + 7'(g_part[2].sum) + 7'(g_part[3].sum);

endmodule

// File: rtl/mul4_fitness_evaluator.sv
// Sequential fitness scorer for bit-sliced 2x2-bit multiplier candidates.
// Optional build macro: MUL4_EVAL_EARLY_EXIT_EN ends a run at the first imperfect vector.
module mul4_fitness_evaluator
   import mul4_eval_pkg::*;
#(
   parameter int          NUM_VECTORS = 16,
   parameter int          SETTLE_CYC  = 1,
   parameter logic [63:0] SEED        = 64'h0123_4567_89AB_CDEF,
   parameter int          FIT_W       = $clog2(NUM_VECTORS*64+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [FIT_W-1:0] fitness,
   output logic             perfect,
   output logic [15:0]      dut_a1,
   output logic [15:0]      dut_a0,
   output logic [15:0]      dut_b1,
   output logic [15:0]      dut_b0,
   input  logic [15:0]      dut_y3,
   input  logic [15:0]      dut_y2,
   input  logic [15:0]      dut_y1,
   input  logic [15:0]      dut_y0
);

   localparam int               IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS-1);
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC-1);
   localparam logic [FIT_W-1:0] FIT_MAX     = FIT_W'(NUM_VECTORS*64);

   state_t           state_reg, state_next;
   logic [63:0]      lfsr_reg, lfsr_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [3:0]       settle_reg, settle_next;
   logic [FIT_W-1:0] acc_reg, acc_next;
   logic [FIT_W-1:0] fitness_reg, fitness_next;
   logic             perfect_reg, perfect_next;
   logic [63:0]      stim_reg, stim_next;

   prod_t            gold;
   logic [63:0]      match_bits;
   logic [6:0]       score;
   logic [FIT_W-1:0] score_sum;
   logic [63:0]      lfsr_step;
   logic             finish;

   assign gold       = golden_product(stim_reg[63:48], stim_reg[47:32], stim_reg[31:16], stim_reg[15:0]);
   assign match_bits = ~({dut_y3, dut_y2, dut_y1, dut_y0} ^ gold);

   mul4_eval_popcount64 u_popcount (
      .bits  (match_bits),
      .count (score)
   );

   assign score_sum = acc_reg + FIT_W'(score);
   assign lfsr_step = {lfsr_reg[62:0], ^(lfsr_reg & LFSR_TAPS)};

`ifdef MUL4_EVAL_EARLY_EXIT_EN
   assign finish = (idx_reg == LAST_IDX) || (score != 7'd64);
`else
   assign finish = (idx_reg == LAST_IDX);
`endif

   always_comb begin
      state_next   = state_reg;
      lfsr_next    = lfsr_reg;
      idx_next     = idx_reg;
      settle_next  = settle_reg;
      acc_next     = acc_reg;
      fitness_next = fitness_reg;
      perfect_next = perfect_reg;
      stim_next    = stim_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               acc_next   = '0;
               lfsr_next  = SEED;
               idx_next   = '0;
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (idx_reg == '0) begin
               stim_next = {EXH_A1, EXH_A0, EXH_B1, EXH_B0};
            end else begin
               stim_next = lfsr_reg;
            end
            settle_next = '0;
            state_next  = SETTLE;
         end
         SETTLE: begin
            if (settle_reg == SETTLE_LAST) begin
               state_next = SCORE;
            end else begin
               settle_next = settle_reg + 4'd1;
            end
         end
         SCORE: begin
            acc_next = score_sum;
            if (idx_reg != '0) begin
               lfsr_next = lfsr_step;
            end
            if (finish) begin
               // Publish at the SCORE edge so fitness is already valid during the done cycle.
               fitness_next = score_sum;
               perfect_next = (score_sum == FIT_MAX);
               state_next   = DONE;
            end else begin
               idx_next   = idx_reg + IDX_W'(1);
               state_next = DRIVE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         lfsr_reg    <= SEED;
         idx_reg     <= '0;
         settle_reg  <= '0;
         acc_reg     <= '0;
         fitness_reg <= '0;
         perfect_reg <= 1'b0;
         stim_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         lfsr_reg    <= lfsr_next;
         idx_reg     <= idx_next;
         settle_reg  <= settle_next;
         acc_reg     <= acc_next;
         fitness_reg <= fitness_next;
         perfect_reg <= perfect_next;
         stim_reg    <= stim_next;
      end
   end

   assign busy    = (state_reg == DRIVE) || (state_reg == SETTLE) || (state_reg == SCORE);
   assign done    = (state_reg == DONE);
   assign fitness = fitness_reg;
   assign perfect = perfect_reg;
   assign dut_a1  = stim_reg[63:48];
   assign dut_a0  = stim_reg[47:32];
   assign dut_b1  = stim_reg[31:16];
   assign dut_b0  = stim_reg[15:0];

endmodule
